// File: rtl/risc_branch_pkg.sv
// Shared types and constants for the branch/PC stage.
package risc_branch_pkg;

  typedef enum logic [1:0] {
    BR_B   = 2'b00,
    BR_BL  = 2'b01,
    BR_BX  = 2'b10,
    BR_BLX = 2'b11
  } br_kind_e;

  localparam logic [2:0] COND_B   = 3'b000;
  localparam logic [2:0] COND_BEQ = 3'b001;
  localparam logic [2:0] COND_BNE = 3'b010;
  localparam logic [2:0] COND_BLT = 3'b011;
  localparam logic [2:0] COND_BLE = 3'b100;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    COMMIT = 2'b10
  } state_e;

  function automatic logic writes_link(input logic [1:0] kind);
    return (kind == BR_BL) || (kind == BR_BLX);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator against the latched Z/N/V flags.
module branch_cond
  import risc_branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [1:0] br_kind,
  input  logic       Z,
  input  logic       N,
  input  logic       V,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    if (br_kind != BR_B) begin
      take = 1'b1;
    end else begin
      case (cond)
        COND_B:   take = 1'b1;
        COND_BEQ: take = Z;
        COND_BNE: take = ~Z;
        COND_BLT: take = N ^ V;
        COND_BLE: take = (N ^ V) | Z;
        default:  take = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_pc_unit.sv
// PC register, status flags and 3-cycle branch FSM (IDLE -> EVAL -> COMMIT).
// Optional saturating taken-branch counter enabled by defining BRANCH_COUNT_EN.
module branch_pc_unit
  import risc_branch_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Z_in,
  input  logic                  N_in,
  input  logic                  V_in,
  input  logic                  load_s,
  input  logic                  pc_inc,
  input  logic                  start,
  input  logic [1:0]            br_kind,
  input  logic [2:0]            cond,
  input  logic [DATA_WIDTH-1:0] sximm8,
  input  logic [DATA_WIDTH-1:0] rd_target,
  output logic [PC_WIDTH-1:0]   PC,
  output logic [DATA_WIDTH-1:0] link_out,
  output logic                  link_we,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  Z_out,
  output logic                  N_out,
  output logic                  V_out
`ifdef BRANCH_COUNT_EN
  ,
  output logic [15:0]           taken_count
`endif
);

  logic [1:0]          state;
  logic [1:0]          kind_r;
  logic [2:0]          cond_r;
  logic [PC_WIDTH-1:0] off_r;
  logic [PC_WIDTH-1:0] tgt_r;
  logic                take;
  logic [PC_WIDTH-1:0] pc_plus1;
  logic [PC_WIDTH-1:0] next_pc;

  // Only the low PC_WIDTH bits of offset and register target reach the PC.
  logic unused_hi;
  assign unused_hi = ^{sximm8[DATA_WIDTH-1:PC_WIDTH], rd_target[DATA_WIDTH-1:PC_WIDTH]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Z_out <= 1'b0;
      N_out <= 1'b0;
      V_out <= 1'b0;
    end else if (load_s) begin
      Z_out <= Z_in;
      N_out <= N_in;
      V_out <= V_in;
    end
  end

  branch_cond u_branch_cond (
    .cond    (cond_r),
    .br_kind (kind_r),
    .Z       (Z_out),
    .N       (N_out),
    .V       (V_out),
    .take    (take)
  );

  always_comb begin
    pc_plus1 = PC + 1'b1;
    next_pc  = pc_plus1;
    if (taken) begin
      next_pc = kind_r[1] ? tgt_r : (pc_plus1 + off_r);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      PC     <= '0;
      taken  <= 1'b0;
      kind_r <= '0;
      cond_r <= '0;
      off_r  <= '0;
      tgt_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            kind_r <= br_kind;
            cond_r <= cond;
            off_r  <= sximm8[PC_WIDTH-1:0];
            tgt_r  <= rd_target[PC_WIDTH-1:0];
            state  <= EVAL;
          end else if (pc_inc) begin
            PC <= pc_plus1;
          end
        end
        EVAL: begin
          taken <= take;
          state <= COMMIT;
        end
        COMMIT: begin
          PC    <= next_pc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == COMMIT);
  assign link_we  = done && writes_link(kind_r);
  assign link_out = {{(DATA_WIDTH - PC_WIDTH){1'b0}}, pc_plus1};

`ifdef BRANCH_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_count <= '0;
    end else if (done && taken && (taken_count != 16'hFFFF)) begin
      taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: vector table plus reset/hold corner sequences.
module tb_branch_pc_unit;
  import risc_branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Z_in = 1'b0, N_in = 1'b0, V_in = 1'b0;
  logic        load_s = 1'b0, pc_inc = 1'b0, start = 1'b0;
  logic [1:0]  br_kind = 2'b00;
  logic [2:0]  cond = 3'b000;
  logic [15:0] sximm8 = 16'h0, rd_target = 16'h0;
  logic [8:0]  PC;
  logic [15:0] link_out;
  logic        link_we, busy, done, taken, Z_out, N_out, V_out;
`ifdef BRANCH_COUNT_EN
  logic [15:0] taken_count;
  int          exp_count = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] model_pc = 9'd0;

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  cnd;
    logic        z, n, v;
    logic [15:0] off, tgt;
    logic [8:0]  start_pc;
    logic        exp_tk;
    logic [8:0]  exp_pc;
    logic        exp_lw;
  } vec_t;

  typedef struct {
    logic        tk;
    logic        lw;
    logic [15:0] link;
  } exp_t;

  vec_t vecs[16];
  exp_t sb[$];

  branch_pc_unit #(.PC_WIDTH(9), .DATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .Z_in      (Z_in),
    .N_in      (N_in),
    .V_in      (V_in),
    .load_s    (load_s),
    .pc_inc    (pc_inc),
    .start     (start),
    .br_kind   (br_kind),
    .cond      (cond),
    .sximm8    (sximm8),
    .rd_target (rd_target),
    .PC        (PC),
    .link_out  (link_out),
    .link_we   (link_we),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .Z_out     (Z_out),
    .N_out     (N_out),
    .V_out     (V_out)
`ifdef BRANCH_COUNT_EN
    ,
    .taken_count (taken_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one branch, tracks it on the scoreboard and checks COMMIT and the new PC.
  task automatic run_branch(input logic [1:0] kind, input logic [2:0] cnd, input logic ld,
                            input logic z, input logic n, input logic v,
                            input logic [15:0] off, input logic [15:0] tgt,
                            input logic exp_tk, input logic [8:0] exp_pc,
                            input logic exp_lw, input logic hold);
    exp_t e;
    exp_t got;
    int   k;
    e.tk   = exp_tk;
    e.lw   = exp_lw;
    e.link = {7'b0, 9'(model_pc + 9'd1)};
    start = 1'b1; br_kind = kind; cond = cnd; sximm8 = off; rd_target = tgt;
    load_s = ld; Z_in = z; N_in = n; V_in = v;
    pc_inc = hold;
    sb.push_back(e);
    step();
    load_s = 1'b0;
    if (!hold) start = 1'b0;
    check("busy_eval", busy, 1);
    if (ld) check("flags", {Z_out, N_out, V_out}, {z, n, v});
    k = 0;
    while (!done && k < 6) begin
      step();
      k++;
    end
    got = sb.pop_front();
    if (!done) begin
      check("done_timeout", done, 1);
    end else begin
      check("taken", taken, got.tk);
      check("link_we", link_we, got.lw);
      check("link_out", link_out, got.link);
      check("pc_hold_commit", PC, model_pc);
    end
    step();
    start = 1'b0;
    pc_inc = 1'b0;
    check("pc_after", PC, exp_pc);
    check("busy_after", busy, 0);
    check("done_after", done, 0);
    model_pc = exp_pc;
`ifdef BRANCH_COUNT_EN
    if (exp_tk) exp_count++;
`endif
  endtask

  initial begin
    vecs[0]  = '{BR_B,   3'b001, 1'b1, 1'b0, 1'b0, 16'd5,    16'h0,    9'd3,   1'b1, 9'd9,   1'b0};
    vecs[1]  = '{BR_B,   3'b001, 1'b0, 1'b0, 1'b0, 16'd5,    16'h0,    9'd3,   1'b0, 9'd4,   1'b0};
    vecs[2]  = '{BR_B,   3'b010, 1'b0, 1'b0, 1'b0, 16'd16,   16'h0,    9'd100, 1'b1, 9'd117, 1'b0};
    vecs[3]  = '{BR_B,   3'b010, 1'b1, 1'b0, 1'b0, 16'd16,   16'h0,    9'd100, 1'b0, 9'd101, 1'b0};
    vecs[4]  = '{BR_B,   3'b011, 1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0,    9'd1,   1'b1, 9'd510, 1'b0};
    vecs[5]  = '{BR_B,   3'b011, 1'b0, 1'b1, 1'b1, 16'hFFFC, 16'h0,    9'd1,   1'b0, 9'd2,   1'b0};
    vecs[6]  = '{BR_B,   3'b100, 1'b1, 1'b0, 1'b0, 16'd3,    16'h0,    9'd20,  1'b1, 9'd24,  1'b0};
    vecs[7]  = '{BR_B,   3'b100, 1'b0, 1'b0, 1'b0, 16'd3,    16'h0,    9'd20,  1'b0, 9'd21,  1'b0};
    vecs[8]  = '{BR_B,   3'b100, 1'b0, 1'b0, 1'b1, 16'd3,    16'h0,    9'd20,  1'b1, 9'd24,  1'b0};
    vecs[9]  = '{BR_B,   3'b101, 1'b1, 1'b0, 1'b0, 16'd3,    16'h0,    9'd20,  1'b0, 9'd21,  1'b0};
    vecs[10] = '{BR_B,   3'b000, 1'b0, 1'b0, 1'b0, 16'h0100, 16'h0,    9'd300, 1'b1, 9'd45,  1'b0};
    vecs[11] = '{BR_BL,  3'b001, 1'b0, 1'b0, 1'b0, 16'd2,    16'h0,    9'd10,  1'b1, 9'd13,  1'b1};
    vecs[12] = '{BR_BX,  3'b001, 1'b0, 1'b0, 1'b0, 16'd9,    16'h0040, 9'd7,   1'b1, 9'd64,  1'b0};
    vecs[13] = '{BR_BLX, 3'b101, 1'b0, 1'b0, 1'b0, 16'd0,    16'hFFFF, 9'd511, 1'b1, 9'd511, 1'b1};
    vecs[14] = '{BR_BX,  3'b000, 1'b0, 1'b0, 1'b0, 16'd0,    16'h1205, 9'd0,   1'b1, 9'd5,   1'b0};
    vecs[15] = '{BR_B,   3'b111, 1'b0, 1'b1, 1'b0, 16'd7,    16'h0,    9'd50,  1'b0, 9'd51,  1'b0};

    // Reset values
    step();
    check("rst_pc", PC, 0);
    check("rst_link_out", link_out, 1);
    check("rst_link_we", link_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_taken", taken, 0);
    check("rst_flags", {Z_out, N_out, V_out}, 0);
    reset = 1'b0;

    // Sequential fetch
    pc_inc = 1'b1;
    for (int i = 0; i < 3; i++) step();
    pc_inc = 1'b0;
    check("inc_pc", PC, 3);
    check("inc_busy", busy, 0);
    model_pc = 9'd3;

    for (int i = 0; i < 16; i++) begin
      // Position the PC with a register-indirect jump, then issue the vector.
      run_branch(BR_BX, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, {7'b0, vecs[i].start_pc},
                 1'b1, vecs[i].start_pc, 1'b0, 1'b0);
      run_branch(vecs[i].kind, vecs[i].cnd, 1'b1, vecs[i].z, vecs[i].n, vecs[i].v,
                 vecs[i].off, vecs[i].tgt, vecs[i].exp_tk, vecs[i].exp_pc, vecs[i].exp_lw, 1'b0);
    end

    // pc_inc and start held high across the whole branch must not add increments.
    run_branch(BR_BX, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0040, 1'b1, 9'd64, 1'b0, 1'b1);
    step();
    check("hold_no_extra", PC, 64);

`ifdef BRANCH_COUNT_EN
    check("taken_count", taken_count, exp_count);
`endif

    // Reset during EVAL discards the pending BNE.
    start = 1'b1; br_kind = 2'b00; cond = 3'b010; sximm8 = 16'd5;
    load_s = 1'b1; Z_in = 1'b1; N_in = 1'b0; V_in = 1'b0;
    step();
    start = 1'b0; load_s = 1'b0;
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_pc", PC, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_taken", taken, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_flags", {Z_out, N_out, V_out}, 0);
`ifdef BRANCH_COUNT_EN
    check("mid_rst_count", taken_count, 0);
`endif
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_done", done, 0);
      check("post_rst_link_we", link_we, 0);
    end
    check("post_rst_pc", PC, 0);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and branch-resolution stage that sits directly downstream of the ALU. It latches the ALU's Z/N/V flags into a status register, evaluates branch conditions against them, and owns the PC register. It computes relative, link and register-indirect targets and hands the link value back to the register file. It runs a small three-state FSM so flag capture, condition evaluation and PC commit occupy distinct cycles.

## Interface
- PC_WIDTH, 9: PC register width.
- DATA_WIDTH, 16: datapath width, used for offset, register target and link.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- Z_in, N_in, V_in  in  1 each  flags from the ALU.
- load_s  in  1  capture Z_in/N_in/V_in into the status register.
- pc_inc  in  1  sequential fetch increment; honoured only in IDLE.
- start  in  1  branch request; sampled only in IDLE.
- br_kind  in  2  00 = B-conditional relative, 01 = BL, 10 = BX, 11 = BLX.
- cond  in  3  000 = B, 001 = BEQ, 010 = BNE, 011 = BLT, 100 = BLE, 101–111 = reserved.
- sximm8  in  DATA_WIDTH  sign-extended branch offset.
- rd_target  in  DATA_WIDTH  register value for BX/BLX.
- PC  out  PC_WIDTH  current program counter.
- link_out  out  DATA_WIDTH  zero-extended PC+1.
- link_we  out  1  write-enable for the link register (R7).
- busy  out  1  high in EVAL and COMMIT.
- done  out  1  one-cycle pulse in COMMIT.
- taken  out  1  registered branch decision.
- Z_out, N_out, V_out  out  1 each  status register contents.

## Operation
- Status register: loads on any edge with load_s=1, in any state.
- FSM states: IDLE → EVAL → COMMIT → IDLE.
  - IDLE → EVAL when start=1.
  - EVAL → COMMIT and COMMIT → IDLE are unconditional.
- In IDLE:
  - start=1 latches br_kind, cond, sximm8 and rd_target.
  - pc_inc=1 with start=0 sets PC ← PC+1.
  - If start=1, pc_inc is ignored.
- In EVAL, taken is registered from the status register value at that cycle, so a load_s in the start cycle is visible:
  - B: always taken.
  - BEQ: Z.
  - BNE: !Z.
  - BLT: N≠V.
  - BLE: (N≠V)|Z.
  - Reserved cond codes: not taken.
  - br_kind 01/10/11: always taken; cond is ignored.
- Target computation:
  - Relative target = PC+1+sximm8[PC_WIDTH-1:0], modulo 2^PC_WIDTH (wrap-around permitted).
  - Register target = rd_target[PC_WIDTH-1:0].
  - Not taken → PC+1.
- In COMMIT:
  - PC is written at the closing edge.
  - link_we=1 only for BL/BLX; link_out = PC+1 computed from the pre-branch PC.
- pc_inc and start outside IDLE are ignored and not queued.
- Reset, including mid-operation: state=IDLE, PC=0, Z/N/V=0, taken=0. The pending branch is discarded and no link write occurs.

## Timing
- start sampled at edge E0 → EVAL during cycle 1.
- taken valid from E1.
- COMMIT during cycle 2: done=1, link_we (if any)=1.
- New PC visible after E2. Next start is accepted in cycle 3.
- Branch latency: 3 cycles, start to new PC.
- Reset values of all outputs:
  - PC=0, link_out=1, link_we=0, busy=0, done=0, taken=0.
  - Z_out, N_out, V_out = 0.

## Configuration
- BRANCH_COUNT_EN defined:
  - Adds output taken_count (16 bits, reset 0).
  - Increments at every COMMIT with taken=1; saturates at 16'hFFFF.
- BRANCH_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package risc_branch_pkg contains:
  - br_kind_e enum.
  - Cond-code localparams.
  - FSM state enum (IDLE/EVAL/COMMIT).
- One combinational sub-module, branch_cond: inputs cond, br_kind, Z, N, V; output take. The top module instantiates it in EVAL.

## Test plan
- Reset, then pc_inc for 3 cycles → PC=3; busy=0.
- Flags Z=1 loaded; start, BEQ, sximm8=5 at PC=3 → done at cycle 2, PC=9, link_we=0.
- Flags N=1, V=0; start, BLT, sximm8=-4 (16'hFFFC) at PC=1 → PC=510 (wrap, 9-bit).
- start, BL, sximm8=2 at PC=10 → link_we=1 in COMMIT, link_out=11, PC=13.
- start, BX, rd_target=16'h0040; pc_inc held high throughout → PC=64, no extra increments.
- BNE issued with Z=1; reset asserted during EVAL → PC=0, state IDLE, taken=0, no done pulse.
